// File: rtl/rate_recovery.sv
// Rate recovery front end: measures high/low half-periods of a synchronized clock,
// emits edge events and qualifies each half-period rate as locked.

package common_p;
  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 6;
  typedef struct packed {
    logic rising_edge;
    logic falling_edge;
    logic any_edge;
  } recovered_events_s;
endpackage

module rate_recovery #(
  parameter int DRIFT_WINDOW = 1,
  parameter int LOCK_COUNT   = 3
) (
  input  common_p::clk_dom_s                   sys_dom_i,
  input  logic                                 recovery_en_i,
  input  logic                                 clear_state_i,
  input  logic                                 sync_clk_i,
  output clks_alot_p::recovered_events_s       recovered_events_o,
  output logic [clks_alot_p::RATE_COUNTER_WIDTH-1:0] high_rate_o,
  output logic [clks_alot_p::RATE_COUNTER_WIDTH-1:0] low_rate_o,
  output logic                                 high_locked_o,
  output logic                                 low_locked_o,
  output logic                                 fully_locked_in_o,
  output logic                                 drift_violation_o,
  output logic                                 stall_violation_o
);
  localparam int W = clks_alot_p::RATE_COUNTER_WIDTH;
  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0] CNT_PRE  = CNT_MAX - W'(1);
  localparam logic [3:0]   LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [W:0]   DRIFT    = (W+1)'(DRIFT_WINDOW);

  typedef enum logic [1:0] {IDLE, ALIGN, MEASURE} state_t;

  logic         clk;
  logic         rst;
  state_t       state;
  logic         prev_q;
  logic [W-1:0] level_cnt;
  logic [3:0]   high_match;
  logic [3:0]   low_match;
  logic         high_seen;
  logic         low_seen;

  logic         rise;
  logic         fall;
  logic         any_edge;
  logic [W:0]   high_diff;
  logic [W:0]   low_diff;
  logic         high_ok;
  logic         low_ok;
  logic [3:0]   high_match_inc;
  logic [3:0]   low_match_inc;

  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.rst;

  assign rise     = sync_clk_i & ~prev_q;
  assign fall     = ~sync_clk_i & prev_q;
  assign any_edge = rise | fall;

  // Distance computed one bit wider so the subtraction never wraps.
  assign high_diff = (level_cnt >= high_rate_o) ? ({1'b0, level_cnt} - {1'b0, high_rate_o})
                                                : ({1'b0, high_rate_o} - {1'b0, level_cnt});
  assign low_diff  = (level_cnt >= low_rate_o)  ? ({1'b0, level_cnt} - {1'b0, low_rate_o})
                                                : ({1'b0, low_rate_o} - {1'b0, level_cnt});
  assign high_ok = (high_diff <= DRIFT);
  assign low_ok  = (low_diff <= DRIFT);

  assign high_match_inc = (high_match == LOCK_CNT) ? LOCK_CNT : high_match + 4'd1;
  assign low_match_inc  = (low_match == LOCK_CNT) ? LOCK_CNT : low_match + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      prev_q             <= 1'b0;
      level_cnt          <= '0;
      high_match         <= '0;
      low_match          <= '0;
      high_seen          <= 1'b0;
      low_seen           <= 1'b0;
      recovered_events_o <= '0;
      high_rate_o        <= '0;
      low_rate_o         <= '0;
      high_locked_o      <= 1'b0;
      low_locked_o       <= 1'b0;
      fully_locked_in_o  <= 1'b0;
      drift_violation_o  <= 1'b0;
      stall_violation_o  <= 1'b0;
    end else begin
      recovered_events_o <= '0;
      drift_violation_o  <= 1'b0;
      stall_violation_o  <= 1'b0;
      fully_locked_in_o  <= high_locked_o & low_locked_o;
      if (recovery_en_i) prev_q <= sync_clk_i;

      if (clear_state_i) begin
        state             <= recovery_en_i ? ALIGN : IDLE;
        level_cnt         <= '0;
        high_rate_o       <= '0;
        low_rate_o        <= '0;
        high_match        <= '0;
        low_match         <= '0;
        high_seen         <= 1'b0;
        low_seen          <= 1'b0;
        high_locked_o     <= 1'b0;
        low_locked_o      <= 1'b0;
        fully_locked_in_o <= 1'b0;
      end else if (!recovery_en_i) begin
        // Rates survive a disable; lock qualification has to start over.
        state         <= IDLE;
        level_cnt     <= '0;
        high_match    <= '0;
        low_match     <= '0;
        high_seen     <= 1'b0;
        low_seen      <= 1'b0;
        high_locked_o <= 1'b0;
        low_locked_o  <= 1'b0;
      end else if (state == IDLE) begin
        state     <= ALIGN;
        level_cnt <= '0;
      end else if (any_edge) begin
        recovered_events_o.rising_edge  <= rise;
        recovered_events_o.falling_edge <= fall;
        recovered_events_o.any_edge     <= 1'b1;
        level_cnt                       <= W'(1);
        if (state == ALIGN) begin
          state <= MEASURE;
        end else if (fall) begin
          high_rate_o <= level_cnt;
          if (!high_seen) begin
            high_seen     <= 1'b1;
            high_match    <= '0;
            high_locked_o <= 1'b0;
          end else if (high_ok) begin
            high_match    <= high_match_inc;
            high_locked_o <= (high_match_inc == LOCK_CNT);
          end else begin
            high_match        <= '0;
            high_locked_o     <= 1'b0;
            drift_violation_o <= high_locked_o;
          end
        end else begin
          low_rate_o <= level_cnt;
          if (!low_seen) begin
            low_seen     <= 1'b1;
            low_match    <= '0;
            low_locked_o <= 1'b0;
          end else if (low_ok) begin
            low_match    <= low_match_inc;
            low_locked_o <= (low_match_inc == LOCK_CNT);
          end else begin
            low_match         <= '0;
            low_locked_o      <= 1'b0;
            drift_violation_o <= low_locked_o;
          end
        end
      end else if (level_cnt == CNT_PRE) begin
        // Counter is about to saturate: report once and realign on the next edge.
        stall_violation_o <= 1'b1;
        level_cnt         <= CNT_MAX;
        state             <= ALIGN;
        high_match        <= '0;
        low_match         <= '0;
        high_seen         <= 1'b0;
        low_seen          <= 1'b0;
        high_locked_o     <= 1'b0;
        low_locked_o      <= 1'b0;
      end else if (level_cnt != CNT_MAX) begin
        level_cnt <= level_cnt + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rate_recovery.sv
// Randomized and directed bench for rate_recovery, checked every cycle against
// a queue-based behavioural model of the measurement and lock rules.

module tb_rate_recovery;
  localparam int W            = clks_alot_p::RATE_COUNTER_WIDTH;
  localparam int MAXC         = (1 << W) - 1;
  localparam int DRIFT_WINDOW = 1;
  localparam int LOCK_COUNT   = 3;
  localparam int VW           = 3 + 2 * W + 5;

  logic clk;
  logic rst;
  common_p::clk_dom_s sys_dom;
  logic recovery_en;
  logic clear_state;
  logic sync_clk;
  clks_alot_p::recovered_events_s events;
  logic [W-1:0] high_rate;
  logic [W-1:0] low_rate;
  logic high_locked;
  logic low_locked;
  logic fully_locked;
  logic drift_violation;
  logic stall_violation;

  assign sys_dom = {clk, rst};

  rate_recovery #(.DRIFT_WINDOW(DRIFT_WINDOW), .LOCK_COUNT(LOCK_COUNT)) dut (
    .sys_dom_i          (sys_dom),
    .recovery_en_i      (recovery_en),
    .clear_state_i      (clear_state),
    .sync_clk_i         (sync_clk),
    .recovered_events_o (events),
    .high_rate_o        (high_rate),
    .low_rate_o         (low_rate),
    .high_locked_o      (high_locked),
    .low_locked_o       (low_locked),
    .fully_locked_in_o  (fully_locked),
    .drift_violation_o  (drift_violation),
    .stall_violation_o  (stall_violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int obs_rise, obs_fall, obs_any, obs_drift, obs_stall;

  // Behavioural model: per-level history of measurements since alignment.
  int  hq[$];
  int  lq[$];
  int  m_run, m_hrate, m_lrate;
  bit  m_active, m_aligned, m_prev;
  bit  m_rise, m_fall, m_any, m_hl, m_ll, m_fl, m_drift, m_stall;

  task automatic model_reset();
    hq.delete(); lq.delete();
    m_run = 0; m_hrate = 0; m_lrate = 0;
    m_active = 0; m_aligned = 0; m_prev = 0;
    m_rise = 0; m_fall = 0; m_any = 0; m_hl = 0; m_ll = 0; m_fl = 0;
    m_drift = 0; m_stall = 0;
  endtask

  // A level is locked once its last LOCK_COUNT+1 measurements all agree pairwise.
  task automatic model_write(input bit is_high, input int v);
    int q[$];
    bit was_locked;
    int last, d;
    if (is_high) q = hq; else q = lq;
    was_locked = (q.size() >= LOCK_COUNT + 1);
    if (q.size() > 0) begin
      last = q[q.size() - 1];
      d = (v > last) ? v - last : last - v;
      if (d > DRIFT_WINDOW) begin
        q.delete();
        if (was_locked) m_drift = 1;
      end
    end
    q.push_back(v);
    if (q.size() > LOCK_COUNT + 1) void'(q.pop_front());
    if (is_high) begin hq = q; m_hrate = v; end
    else begin lq = q; m_lrate = v; end
  endtask

  task automatic model_step(input bit en, input bit clr, input bit s);
    bit old_hl, old_ll;
    old_hl = m_hl; old_ll = m_ll;
    m_rise = 0; m_fall = 0; m_any = 0; m_drift = 0; m_stall = 0;
    m_fl = old_hl & old_ll;
    if (clr) begin
      m_hrate = 0; m_lrate = 0; hq.delete(); lq.delete();
      m_run = 0; m_active = en; m_aligned = 0; m_fl = 0;
      if (en) m_prev = s;
    end else if (!en) begin
      m_active = 0; m_aligned = 0; m_run = 0; hq.delete(); lq.delete();
    end else if (!m_active) begin
      m_active = 1; m_aligned = 0; m_prev = s; m_run = 0;
    end else begin
      m_rise = s & ~m_prev;
      m_fall = ~s & m_prev;
      m_any  = m_rise | m_fall;
      m_prev = s;
      if (m_any) begin
        if (m_aligned) model_write(m_fall, m_run);
        else m_aligned = 1;
        m_run = 1;
      end else if (m_run == MAXC - 1) begin
        m_stall = 1; m_run = MAXC; hq.delete(); lq.delete(); m_aligned = 0;
      end else if (m_run < MAXC) begin
        m_run++;
      end
    end
    m_hl = (hq.size() >= LOCK_COUNT + 1);
    m_ll = (lq.size() >= LOCK_COUNT + 1);
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {events.rising_edge, events.falling_edge, events.any_edge, high_rate, low_rate,
            high_locked, low_locked, fully_locked, drift_violation, stall_violation};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_rise, m_fall, m_any, W'(m_hrate), W'(m_lrate), m_hl, m_ll, m_fl, m_drift, m_stall};
  endfunction

  // One clock of stimulus, model update and full-output comparison.
  task automatic step(input bit en, input bit clr, input bit s, input string name);
    recovery_en = en; clear_state = clr; sync_clk = s;
    @(posedge clk);
    model_step(en, clr, s);
    #1;
    compared++;
    if (dut_vec() !== mdl_vec()) begin
      mismatched++;
      $display("FAIL %s cycle_outputs: got %h expected %h at %0t", name, dut_vec(), mdl_vec(), $time);
    end
    obs_rise  += int'(events.rising_edge);
    obs_fall  += int'(events.falling_edge);
    obs_any   += int'(events.any_edge);
    obs_drift += int'(drift_violation);
    obs_stall += int'(stall_violation);
  endtask

  task automatic run_periods(input int hi, input int lo, input int n, input string name);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1, 0, 1, name);
      for (int i = 0; i < lo; i++) step(1, 0, 0, name);
      $display("%s period hi=%0d lo=%0d high_rate=%0d low_rate=%0d locks=%b%b%b",
               name, hi, lo, high_rate, low_rate, high_locked, low_locked, fully_locked);
    end
  endtask

  task automatic clear_counts();
    obs_rise = 0; obs_fall = 0; obs_any = 0; obs_drift = 0; obs_stall = 0;
  endtask

  task automatic test_reset();
    rst = 1; recovery_en = 0; clear_state = 0; sync_clk = 0;
    model_reset();
    #3;
    compared++;
    if (dut_vec() !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got %h expected 0", dut_vec());
    end
    #9 rst = 0;
    step(0, 0, 0, "reset_idle");
    $display("test_reset done");
  endtask

  task automatic test_lock_5050();
    clear_counts();
    step(1, 1, 0, "lock_clr");
    run_periods(4, 4, 4, "lock5050");
    compared++;
    if (high_locked !== 1'b1 || low_locked !== 1'b0) begin
      mismatched++;
      $display("FAIL lock_after4: got hl=%b ll=%b expected hl=1 ll=0", high_locked, low_locked);
    end
    run_periods(4, 4, 4, "lock5050");
    compared++;
    if ({high_rate, low_rate, high_locked, low_locked, fully_locked} !== {W'(4), W'(4), 3'b111}) begin
      mismatched++;
      $display("FAIL lock_final: got hr=%0d lr=%0d locks=%b%b%b expected 4 4 111",
               high_rate, low_rate, high_locked, low_locked, fully_locked);
    end
    compared++;
    if (obs_rise != 8 || obs_fall != 8 || obs_any != 16) begin
      mismatched++;
      $display("FAIL lock_events: got rise=%0d fall=%0d any=%0d expected 8 8 16", obs_rise, obs_fall, obs_any);
    end
  endtask

  task automatic test_non5050();
    clear_counts();
    step(1, 1, 0, "n5050_clr");
    run_periods(4, 3, 7, "non5050");
    compared++;
    if ({high_rate, low_rate, high_locked, low_locked, fully_locked} !== {W'(4), W'(3), 3'b111}
        || obs_drift != 0 || obs_stall != 0) begin
      mismatched++;
      $display("FAIL non5050: got hr=%0d lr=%0d locks=%b%b%b drift=%0d stall=%0d expected 4 3 111 0 0",
               high_rate, low_rate, high_locked, low_locked, fully_locked, obs_drift, obs_stall);
    end
  endtask

  task automatic test_drift();
    step(1, 1, 0, "drift_clr");
    run_periods(4, 4, 6, "drift_lock");
    clear_counts();
    run_periods(3, 4, 1, "drift_in");
    compared++;
    if (high_rate !== W'(3) || high_locked !== 1'b1 || obs_drift != 0) begin
      mismatched++;
      $display("FAIL drift_within: got hr=%0d hl=%b pulses=%0d expected 3 1 0", high_rate, high_locked, obs_drift);
    end
    run_periods(1, 4, 1, "drift_out");
    compared++;
    if (obs_drift != 1 || high_locked !== 1'b0 || fully_locked !== 1'b0 || low_locked !== 1'b1) begin
      mismatched++;
      $display("FAIL drift_outside: got pulses=%0d hl=%b ll=%b fl=%b expected 1 0 1 0",
               obs_drift, high_locked, low_locked, fully_locked);
    end
    run_periods(4, 4, 4, "drift_relock");
    compared++;
    if (high_locked !== 1'b1 || fully_locked !== 1'b1) begin
      mismatched++;
      $display("FAIL drift_relock: got hl=%b fl=%b expected 1 1", high_locked, fully_locked);
    end
  endtask

  task automatic test_stall();
    step(1, 1, 0, "stall_clr");
    run_periods(4, 4, 6, "stall_lock");
    clear_counts();
    for (int i = 0; i < 80; i++) step(1, 0, 1, "stall_hold");
    compared++;
    if (obs_stall != 1 || high_locked !== 1'b0 || low_locked !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_pulse: got pulses=%0d hl=%b ll=%b expected 1 0 0", obs_stall, high_locked, low_locked);
    end
    run_periods(0, 4, 1, "stall_resume");
    compared++;
    if (high_rate !== W'(4) || obs_fall != 1) begin
      mismatched++;
      $display("FAIL stall_align_edge: got hr=%0d falls=%0d expected 4 1", high_rate, obs_fall);
    end
    run_periods(4, 4, 5, "stall_relock");
  endtask

  task automatic test_clear();
    step(1, 1, 0, "clear_pre");
    run_periods(4, 4, 6, "clear_lock");
    step(1, 1, 1, "clear_on_rise");
    compared++;
    if ({events, high_rate, low_rate, high_locked, low_locked} !== '0) begin
      mismatched++;
      $display("FAIL clear_state: got ev=%b hr=%0d lr=%0d hl=%b ll=%b expected all 0",
               events, high_rate, low_rate, high_locked, low_locked);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 1, "clear_tail");
    run_periods(4, 4, 4, "clear_relock");
    compared++;
    if (low_locked !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_early_lock: got ll=%b expected 0", low_locked);
    end
    run_periods(4, 4, 1, "clear_relock");
    compared++;
    if ({high_locked, low_locked, fully_locked} !== 3'b111) begin
      mismatched++;
      $display("FAIL clear_relock: got %b%b%b expected 111", high_locked, low_locked, fully_locked);
    end
  endtask

  task automatic test_disable();
    step(1, 1, 0, "dis_clr");
    run_periods(4, 4, 6, "dis_lock");
    step(0, 0, 1, "dis_first");
    clear_counts();
    for (int i = 0; i < 20; i++) step(0, 0, i[1], "dis_toggle");
    compared++;
    if (obs_any != 0 || high_rate !== W'(4) || low_rate !== W'(4) || high_locked !== 1'b0) begin
      mismatched++;
      $display("FAIL disable: got events=%0d hr=%0d lr=%0d hl=%b expected 0 4 4 0",
               obs_any, high_rate, low_rate, high_locked);
    end
    step(1, 0, 0, "dis_reenable");
    run_periods(4, 4, 6, "dis_relock");
  endtask

  task automatic test_async_reset();
    run_periods(4, 4, 2, "arst_pre");
    step(1, 0, 1, "arst_mid");
    #3 rst = 1;
    #1;
    model_reset();
    compared++;
    if (dut_vec() !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    #2 rst = 0;
    step(1, 0, 0, "arst_after");
    run_periods(4, 4, 5, "arst_relock");
  endtask

  task automatic test_random();
    int r, hi, lo;
    step(1, 1, 0, "rand_clr");
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        step(1, 1, 1'($urandom_range(0, 1)), "rand_clear");
      end else if (r == 1) begin
        for (int i = 0; i < 3; i++) step(0, 0, 1'($urandom_range(0, 1)), "rand_disable");
      end else if (r == 2) begin
        for (int i = 0; i < 70; i++) step(1, 0, 1, "rand_stall");
      end else begin
        hi = (r < 15) ? int'($urandom_range(3, 5)) : int'($urandom_range(1, 8));
        lo = (r < 15) ? int'($urandom_range(3, 5)) : int'($urandom_range(1, 8));
        run_periods(hi, lo, 1, "random");
      end
    end
  endtask

  initial begin
    rst = 1; recovery_en = 0; clear_state = 0; sync_clk = 0;
    clear_counts();
    test_reset();
    test_lock_5050();
    test_non5050();
    test_drift();
    test_stall();
    test_clear();
    test_disable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rate_recovery.md
Name: rate_recovery

Overview:
- Recovery front end of the clock-recovery path. Measures the high and low half-periods of an already-synchronized incoming clock.
- Emits per-edge event pulses and the measured high/low rates.
- Qualifies each rate as locked once consecutive measurements agree within a drift window.
- Its outputs are the recovery feedback consumed by the generation block: recovered_events, fully_locked_in, high_rate, low_rate.

Parameters:
- DRIFT_WINDOW, default 1: maximum absolute difference (cycles) between consecutive same-level measurements that still counts as a match.
- LOCK_COUNT, default 3: consecutive matches required before a level is locked; range 1..15.
- Rate width is W = clks_alot_p::RATE_COUNTER_WIDTH. It is a package constant, not a parameter.

Ports:
- sys_dom_i  input  common_p::clk_dom_s  single system clock plus reset bundle; reset is asynchronous, active-high.
- recovery_en_i  input  1  enables measurement; low = idle.
- clear_state_i  input  1  synchronous clear of all measurement/lock state.
- sync_clk_i  input  1  incoming clock, already synchronized to sys_dom_i.
- recovered_events_o  output  clks_alot_p::recovered_events_s  registered pulses; fields rising_edge, falling_edge, any_edge.
- high_rate_o  output  W  last high half-period, in cycles.
- low_rate_o  output  W  last low half-period, in cycles.
- high_locked_o  output  1  high rate locked.
- low_locked_o  output  1  low rate locked.
- fully_locked_in_o  output  1  high_locked_o & low_locked_o, registered.
- drift_violation_o  output  1  1-cycle pulse: a locked level measured outside DRIFT_WINDOW.
- stall_violation_o  output  1  1-cycle pulse: level counter saturated with no edge.

Behaviour:
- Reset: all outputs 0, all internal state 0, FSM in IDLE.
- Edge detect: prev_q <= sync_clk_i every enabled cycle. Rise = sync_clk_i & ~prev_q; fall = ~sync_clk_i & prev_q.
- Event pulses are registered. An edge seen at cycle t produces its event pulse at t+1; rate, lock and violation updates for that edge also appear at t+1.
- Level counter (W bits):
  - On an edge, the counter loads 1.
  - Otherwise it increments, saturating at 2^W-1.
  - The measurement taken at an edge is the counter value before the load, i.e. cycles the previous level was held.
- FSM:
  - IDLE: recovery_en_i=0. Counter held at 0, no events, rates and locks held. Go to ALIGN when recovery_en_i=1.
  - ALIGN: first edge is used for phase alignment only. Emit its event, load counter, write no rate. Go to MEASURE.
  - MEASURE: every edge writes its measurement. A fall writes high_rate_o; a rise writes low_rate_o.
- Lock, per level, using match_cnt (4 bits):
  - First write after ALIGN or after a lock loss: store the rate, match_cnt=0.
  - Subsequent write with |new - stored| <= DRIFT_WINDOW: match_cnt increments, saturating at LOCK_COUNT. The level is locked while match_cnt == LOCK_COUNT.
  - Otherwise: match_cnt=0, locked=0. If that level was locked, pulse drift_violation_o.
  - The rate register always takes the new measurement.
- Difference is computed at W+1 bits; no wrap.
- Stall:
  - Counter reaching 2^W-1 pulses stall_violation_o once, clears both locks and match_cnts, and sends the FSM to ALIGN.
  - The edge that ends a stall is treated as an ALIGN edge.
- recovery_en_i falling mid-operation: go to IDLE. Locks clear, rates hold, and any pending event pulse still issues.
- clear_state_i:
  - Highest priority over edges and the stall check.
  - Zeroes rates, locks, match_cnts and counter; suppresses event pulses that cycle.
  - FSM goes to ALIGN if enabled, else IDLE.
- Simultaneous drift on one level while the other is locked: only the offending level drops. fully_locked_in_o falls the next cycle.

Test Plan:
- Lock-in, 50-50: recovery_en_i=1, sync_clk_i 4 high / 4 low, LOCK_COUNT=3.
  - Each edge pulses rising_edge/falling_edge one cycle after it.
  - high_rate_o and low_rate_o settle to 4.
  - high_locked_o rises on the 4th high measurement, low_locked_o on the 4th low measurement.
  - fully_locked_in_o rises one cycle after both locks.
- Non-50-50: 4 high / 3 low.
  - Required: high_rate_o=4, low_rate_o=3, both locked, no violations.
- Drift within and outside the window, starting from the locked 4/4 clock:
  - One 3-cycle high -> high_rate_o=3, lock kept, no pulse.
  - A subsequent 1-cycle high -> drift_violation_o pulses once, high_locked_o=0, fully_locked_in_o=0; high relocks after 3 further matching highs.
- Stall: while locked, hold sync_clk_i high.
  - Required: stall_violation_o pulses exactly once when the counter hits 2^W-1, both locks clear.
  - Clock resumes -> first edge writes no rate.
- Clear mid-operation: assert clear_state_i on the same cycle as a rise while locked.
  - Required: no event pulse, rates=0, locks=0.
  - Relock requires an ALIGN edge plus 4 measurements per level.
- Reset and disable:
  - Async reset mid-period -> all outputs 0 immediately.
  - recovery_en_i=0 -> no events while sync_clk_i toggles; rates hold their last values.
